// File: rtl/watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : watchdog                                                        |
// | Purpose  : Memory-mapped watchdog slave on the picorv32 native bus. A      |
// |            prescaled down-counter must be kicked with the key sequence     |
// |            0xA5 then 0x5A written to KICK. The first expiry raises an      |
// |            early-warning interrupt; the second expiry pulses a reset       |
// |            request for RST_CYCLES clocks.                                  |
// | Ports    : clk, reset (async, active high)                                 |
// |            select/wstrb/addr/data_i -> ready/data_o  (bus slave)           |
// |            irq        level early-warning interrupt (warn & IRQ_EN)        |
// |            wdt_reset  reset request pulse toward reset_control            |
// | Map      : 0x0 CTRL {LOCK,IRQ_EN,EN}  0x4 RELOAD  0x8 KICK/STATUS         |
// |            0xC COUNT (read only)                                           |
// | Options  : define WDT_WINDOW_EN to reject kicks arriving in RUN while      |
// |            COUNT > RELOAD/2 (early kick -> key_err and immediate BITE).    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module watchdog #(
  parameter int CNT_WIDTH  = 24,
  parameter int PRESCALE   = 1000,
  parameter int RST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        irq,
  output logic        wdt_reset
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [PW-1:0]        C_PRE_TOP  = PW'(PRESCALE - 1);
  localparam logic [BW-1:0]        C_BITE_TOP = BW'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [31:0]          C_KEY1     = 32'h0000_00A5;
  localparam logic [31:0]          C_KEY2     = 32'h0000_005A;

  typedef enum logic [1:0] {ST_DISABLED, ST_RUN, ST_WARN, ST_BITE} wdt_state_t;
  typedef enum logic       {KEY_IDLE, KEY_GOT_A5}                   key_state_t;

  wdt_state_t           r_state, state_n;
  key_state_t           r_key, key_n;
  logic [2:0]           r_ctrl;
  logic [CNT_WIDTH-1:0] r_reload;
  logic [CNT_WIDTH-1:0] r_count, count_n;
  logic [PW-1:0]        r_pre, pre_n;
  logic [BW-1:0]        r_bite, bite_n;
  logic                 r_warn, warn_n;
  logic                 r_key_err, key_err_n;
  logic                 wdt_reset_n;

  logic                 w_access, w_write;
  logic                 w_ctrl_wr, w_reload_wr, w_kick_wr, w_kick;
  logic                 w_tick, w_early;
  logic [CNT_WIDTH-1:0] w_reload_eff;
  logic [31:0]          w_rdata;

  // A second edge with select still high only clears ready; it is not a new access.
  assign w_access     = select & ~ready;
  assign w_write      = w_access & (wstrb != 4'b0000);
  assign w_ctrl_wr    = w_write & (addr == 4'h0) & ~r_ctrl[2];
  assign w_reload_wr  = w_write & (addr == 4'h4) & ~r_ctrl[2];
  assign w_kick_wr    = w_write & (addr == 4'h8);
  assign w_kick       = w_kick_wr & (r_key == KEY_GOT_A5) & (data_i == C_KEY2);
  assign w_tick       = (r_pre == '0);
  assign w_reload_eff = (r_reload == '0) ? C_CNT_ONE : r_reload;

`ifdef WDT_WINDOW_EN
  assign w_early = (r_state == ST_RUN) && (r_count > (w_reload_eff >> 1));
`else
  assign w_early = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (addr)
      4'h0:    w_rdata[2:0]           = r_ctrl;
      4'h4:    w_rdata[CNT_WIDTH-1:0] = r_reload;
      4'h8:    w_rdata[1:0]           = {r_key_err, r_warn};
      4'hC:    w_rdata[CNT_WIDTH-1:0] = r_count;
      default: w_rdata = '0;
    endcase
  end

  always_comb begin
    state_n     = r_state;
    key_n       = r_key;
    count_n     = r_count;
    pre_n       = r_pre;
    bite_n      = r_bite;
    warn_n      = r_warn;
    key_err_n   = r_key_err;
    wdt_reset_n = wdt_reset;

    // Key sequencer runs in every state; only KICK writes move it.
    if (w_kick_wr) begin
      if ((r_key == KEY_IDLE) && (data_i == C_KEY1)) begin
        key_n = KEY_GOT_A5;
      end else begin
        key_n = KEY_IDLE;
        if (!w_kick) key_err_n = 1'b1;
      end
    end

    case (r_state)
      ST_DISABLED: begin
        if (w_ctrl_wr && data_i[0] && !r_ctrl[0]) begin
          count_n = w_reload_eff;
          pre_n   = C_PRE_TOP;
          state_n = ST_RUN;
        end
      end

      ST_RUN, ST_WARN: begin
        // The prescaler keeps its cadence even when a tick is dropped.
        pre_n = w_tick ? C_PRE_TOP : r_pre - 1'b1;
        if (w_ctrl_wr) begin
          if (!data_i[0]) begin
            state_n = ST_DISABLED;
            warn_n  = 1'b0;
          end
        end else if (w_kick) begin
          if (w_early) begin
            key_err_n   = 1'b1;
            wdt_reset_n = 1'b1;
            bite_n      = C_BITE_TOP;
            state_n     = ST_BITE;
          end else begin
            count_n   = w_reload_eff;
            warn_n    = 1'b0;
            key_err_n = 1'b0;
            pre_n     = C_PRE_TOP;
            state_n   = ST_RUN;
          end
        end else if (w_tick) begin
          if (r_count <= C_CNT_ONE) begin
            if (r_state == ST_RUN) begin
              warn_n  = 1'b1;
              count_n = w_reload_eff;
              state_n = ST_WARN;
            end else begin
              wdt_reset_n = 1'b1;
              bite_n      = C_BITE_TOP;
              state_n     = ST_BITE;
            end
          end else begin
            count_n = r_count - 1'b1;
          end
        end
      end

      ST_BITE: begin
        if (r_bite == '0) begin
          wdt_reset_n = 1'b0;
          warn_n      = 1'b0;
          count_n     = w_reload_eff;
          pre_n       = C_PRE_TOP;
          // An EN=0 written during the bite takes effect once it completes.
          state_n     = r_ctrl[0] ? ST_RUN : ST_DISABLED;
        end else begin
          bite_n = r_bite - 1'b1;
        end
      end

      default: state_n = ST_DISABLED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_DISABLED;
      r_key     <= KEY_IDLE;
      r_ctrl    <= '0;
      r_reload  <= '1;
      r_count   <= '1;
      r_pre     <= C_PRE_TOP;
      r_bite    <= '0;
      r_warn    <= 1'b0;
      r_key_err <= 1'b0;
      wdt_reset <= 1'b0;
      irq       <= 1'b0;
      ready     <= 1'b0;
      data_o    <= '0;
    end else begin
      r_state   <= state_n;
      r_key     <= key_n;
      r_count   <= count_n;
      r_pre     <= pre_n;
      r_bite    <= bite_n;
      r_warn    <= warn_n;
      r_key_err <= key_err_n;
      wdt_reset <= wdt_reset_n;
      irq       <= r_warn & r_ctrl[1];
      ready     <= w_access;
      data_o    <= (w_access && !w_write) ? w_rdata : 32'h0;
      if (w_ctrl_wr)   r_ctrl   <= data_i[2:0];
      if (w_reload_wr) r_reload <= data_i[CNT_WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_watchdog                                                     |
// | Purpose  : Self-checking bench for watchdog (PRESCALE=4, RST_CYCLES=16,    |
// |            CNT_WIDTH=24): register vector table plus timed sequences.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_watchdog;
  localparam int CNT_WIDTH  = 24;
  localparam int PRESCALE   = 4;
  localparam int RST_CYCLES = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        select = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] data_i = 32'h0;
  logic        ready;
  logic [31:0] data_o;
  logic        irq;
  logic        wdt_reset;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  watchdog #(.CNT_WIDTH(CNT_WIDTH), .PRESCALE(PRESCALE), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .reset(reset), .select(select), .wstrb(wstrb), .addr(addr),
    .data_i(data_i), .ready(ready), .data_o(data_o), .irq(irq), .wdt_reset(wdt_reset)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One bus access: select is raised just after an edge, the next edge commits it.
  task automatic bus(input logic wr, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    select = 1'b1;
    wstrb  = wr ? 4'hF : 4'h0;
    addr   = a;
    data_i = d;
    @(posedge clk); #1;
    check("ready_high", ready, 1);
    rd     = data_o;
    select = 1'b0;
    wstrb  = 4'h0;
    @(posedge clk); #1;
    check("ready_low", ready, 0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] v;
    bus(1'b1, a, d, v);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(1'b0, a, 32'h0, v);
    check(name, v, exp);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    select = 1'b0;
    wstrb  = 4'h0;
    addr   = 4'h0;
    data_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl [16];
    logic [31:0] v;
    logic [31:0] min_cnt;
    int          t0, t1, t2, n;
    logic        seen_irq, seen_rst;

    // ---------------- reset state and register vectors ----------------
    do_reset();
    check("rst_ready", ready, 0);
    check("rst_data_o", data_o, 0);
    check("rst_irq", irq, 0);
    check("rst_wdt_reset", wdt_reset, 0);

    tbl[0]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0000};
    tbl[1]  = '{1'b0, 4'h4, 32'h0,         32'h00FF_FFFF};
    tbl[2]  = '{1'b0, 4'h8, 32'h0,         32'h0000_0000};
    tbl[3]  = '{1'b0, 4'hC, 32'h0,         32'h00FF_FFFF};
    tbl[4]  = '{1'b0, 4'h2, 32'h0,         32'h0000_0000};
    tbl[5]  = '{1'b1, 4'h4, 32'hABCD_EF12, 32'h0};
    tbl[6]  = '{1'b0, 4'h4, 32'h0,         32'h00CD_EF12};
    tbl[7]  = '{1'b1, 4'h6, 32'hFFFF_FFFF, 32'h0};
    tbl[8]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0000};
    tbl[9]  = '{1'b1, 4'h4, 32'h0000_000A, 32'h0};
    tbl[10] = '{1'b0, 4'h4, 32'h0,         32'h0000_000A};
    tbl[11] = '{1'b0, 4'hC, 32'h0,         32'h00FF_FFFF};
    tbl[12] = '{1'b1, 4'h8, 32'h0000_00A5, 32'h0};
    tbl[13] = '{1'b1, 4'h8, 32'h0000_005A, 32'h0};
    tbl[14] = '{1'b0, 4'hC, 32'h0,         32'h00FF_FFFF};
    tbl[15] = '{1'b0, 4'hE, 32'h0,         32'h0000_0000};

    for (int i = 0; i < 16; i++) begin
      bus(tbl[i].wr, tbl[i].addr, tbl[i].wdata, v);
      if (!tbl[i].wr) check($sformatf("vec%0d_rdata", i), v, tbl[i].exp);
    end

    // ---------------- expiry: warn, bite, recovery ----------------
    do_reset();
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h3);
    t0 = cyc - 1;                     // cycle index of the CTRL commit edge
    n = 0;
    while (!irq && n < 200) begin @(posedge clk); #1; n++; end
    check_range("irq_rise_latency", cyc - t0, 40, 41);
    rd_chk("status_warn", 4'h8, 32'h1);
    n = 0;
    while (!wdt_reset && n < 200) begin @(posedge clk); #1; n++; end
    t1 = cyc;
    check_range("bite_latency", t1 - t0, 80, 81);
    n = 0;
    while (wdt_reset && n < 100) begin @(posedge clk); #1; n++; end
    t2 = cyc;
    check("bite_width", t2 - t1, RST_CYCLES);
    rd_chk("count_after_bite", 4'hC, 32'd10);
    check("irq_after_bite", irq, 0);
    rd_chk("status_after_bite", 4'h8, 32'h0);

    // asynchronous reset while biting
    n = 0;
    while (!wdt_reset && n < 200) begin @(posedge clk); #1; n++; end
    check("second_bite_seen", wdt_reset, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_rst_wdt_reset", wdt_reset, 0);
    check("async_rst_irq", irq, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd_chk("ctrl_after_async_rst", 4'h0, 32'h0);
    rd_chk("count_after_async_rst", 4'hC, 32'h00FF_FFFF);

    // ---------------- periodic kicking every 30 clk ----------------
    do_reset();
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h1);
    min_cnt  = 32'hFFFF_FFFF;
    seen_irq = 1'b0;
    seen_rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      wr(4'h8, 32'hA5);
      wr(4'h8, 32'h5A);
      for (int r = 0; r < 13; r++) begin
        bus(1'b0, 4'hC, 32'h0, v);
        if (v < min_cnt) min_cnt = v;
        if (irq) seen_irq = 1'b1;
        if (wdt_reset) seen_rst = 1'b1;
      end
    end
    check_range("kick_min_count", int'(min_cnt), 3, 10);
    check("kick_no_irq", seen_irq, 0);
    check("kick_no_wdt_reset", seen_rst, 0);

    // ---------------- bad key ----------------
    do_reset();
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h1);                  // commit E0
    wait_cycles(8);
    wr(4'h8, 32'hA5);                 // E10
    wr(4'h8, 32'h33);                 // E12
    rd_chk("status_key_err", 4'h8, 32'h2);   // E14
    rd_chk("count_no_reload", 4'hC, 32'd7);  // E16
    wr(4'h8, 32'hA5);                 // E18
    wr(4'h8, 32'h5A);                 // E20
    rd_chk("status_after_good_kick", 4'h8, 32'h0);
    rd_chk("count_after_good_kick", 4'hC, 32'd10);

    // ---------------- lock ----------------
    do_reset();
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h5);                  // E0
    wr(4'h0, 32'h0);                  // E2
    wr(4'h4, 32'd5);                  // E4
    rd_chk("ctrl_locked", 4'h0, 32'h5);
    rd_chk("reload_locked", 4'h4, 32'd10);
    rd_chk("count_running_locked", 4'hC, 32'd8);   // E10

    // ---------------- simultaneous events ----------------
    do_reset();
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h1);                  // E0
    wait_cycles(4);
    wr(4'h8, 32'hA5);                 // E6
    wr(4'h8, 32'h5A);                 // E8, coincides with terminal tick
    rd_chk("kick_beats_tick_status", 4'h8, 32'h0);   // E10
    rd_chk("kick_beats_tick_count", 4'hC, 32'd2);    // E12
    wait_cycles(2);
    wr(4'h0, 32'h1);                  // E16, coincides with terminal tick
    rd_chk("ctrl_drops_tick_status", 4'h8, 32'h0);   // E18
    wait_cycles(2);
    rd_chk("warn_after_next_tick", 4'h8, 32'h1);     // E22
    rd_chk("count_after_warn", 4'hC, 32'd2);         // E24

`ifdef WDT_WINDOW_EN
    // ---------------- kick window ----------------
    do_reset();
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h1);                  // E0
    wait_cycles(2);
    wr(4'h8, 32'hA5);                 // E4
    wr(4'h8, 32'h5A);                 // E6, COUNT=9 -> early
    check("early_kick_bite", wdt_reset, 1);
    rd_chk("early_kick_status", 4'h8, 32'h2);
    n = 0;
    while (wdt_reset && n < 100) begin @(posedge clk); #1; n++; end
    check("early_bite_ended", wdt_reset, 0);
    wait_cycles(23);
    wr(4'h8, 32'hA5);
    wr(4'h8, 32'h5A);                 // COUNT=4 -> accepted
    rd_chk("late_kick_count", 4'hC, 32'd10);
    check("late_kick_no_bite", wdt_reset, 0);
    rd_chk("late_kick_status", 4'h8, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
